exc_vector_ctrl: RTL and testbench
==================================

Name: exc_vector_ctrl

Overview:
- Exception sequencer for the multicycle datapath. Sits directly upstream of the memory-address mux and drives its 3-bit IorD select.
- On an invalid-opcode, overflow or divide-by-zero event it saves the faulting PC into EPC and steers the mux to the fixed vector byte address 253, 254 or 255.
- It waits for the memory read, then loads PC with the zero-extended handler byte.
- While idle it passes the control unit's IorD select through unchanged.

Parameters:
- MEM_LAT, 1, read latency in cycles: the number of cycles from an address being presented to the mux until mem_data is valid. Legal range 1..7.
- PC_ADJ, 4, amount subtracted from pc_in to form EPC. PC was already incremented at fetch.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cu_iord  in  3  IorD select from the control unit.
- exc_opcode  in  1  invalid-opcode event, single-cycle pulse.
- exc_ovf  in  1  ALU overflow event, single-cycle pulse.
- exc_div0  in  1  divide-by-zero event, single-cycle pulse.
- pc_in  in  32  current PC register value.
- mem_data  in  32  memory read data.
- iord_sel  out  3  select to the address mux.
- epc  out  32  exception PC register.
- epc_write  out  1  one-cycle strobe, asserted when epc is loaded.
- pc_next  out  32  value to be written into PC.
- pc_write  out  1  one-cycle PC write strobe.
- cause  out  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 div0.
- busy  out  1  high in every state except IDLE; the control unit stalls while high.

Behaviour:
- Reset (asynchronous, any state): go to IDLE. Reset values: epc=0, cause=00, pc_next=0, epc_write=0, pc_write=0, busy=0, wait counter=0. iord_sel then equals cu_iord.
- States: IDLE, SAVE, WAIT, LOAD.
- IDLE:
  - iord_sel = cu_iord, combinationally.
  - If any exc_* is high at the clock edge: latch cause, go to SAVE.
  - Priority when several are high together: opcode > overflow > div0. Lower-priority events are dropped.
- SAVE (1 cycle):
  - Drive the vector select: opcode -> 3'b001 (address 253), overflow -> 3'b010 (254), div0 -> 3'b011 (255).
  - Assert epc_write. At the end of the cycle, epc <= pc_in - PC_ADJ (32-bit, modulo 2^32).
  - Example: pc_in=0 gives epc=32'hFFFF_FFFC.
  - Wait counter <= MEM_LAT-1. Go to WAIT.
- WAIT:
  - Hold the vector select. Counter decrements each cycle.
  - When the counter is 0, go to LOAD.
  - With MEM_LAT=1, WAIT lasts exactly 1 cycle (counter already 0).
- LOAD (1 cycle):
  - Hold the vector select. pc_next = {24'b0, mem_data[7:0]}, combinational from mem_data. Assert pc_write.
  - Next state IDLE. cause holds its value until the next exception.
- Total latency is MEM_LAT+2 cycles from the event edge to the pc_write cycle. busy is high for exactly those cycles.
- exc_* inputs are ignored while not in IDLE. No queuing.
- An event in the same cycle LOAD returns to IDLE is also ignored. The first cycle back in IDLE samples normally.
- epc_write and pc_write are never high in the same cycle. Outside SAVE and LOAD respectively, each is 0.
- Upper bits of mem_data are ignored.

Test Plan:
- Reset mid-WAIT (MEM_LAT=3): assert reset_n=0 in the 2nd WAIT cycle -> immediately busy=0, epc=0, cause=00, iord_sel=cu_iord. No pc_write follows.
- Passthrough: idle, sweep cu_iord 0..7 -> iord_sel equals cu_iord every cycle; busy, epc_write and pc_write stay 0.
- Overflow (MEM_LAT=1): pc_in=32'h0000_0104, exc_ovf pulse, memory byte at 254 = 8'hA0. Required response:
  - SAVE: iord_sel=3'b010 and epc_write=1; epc=32'h100 afterwards.
  - WAIT: 1 cycle.
  - LOAD: pc_write=1 with pc_next=32'h0000_00A0; cause=10.
- Simultaneous events: exc_opcode=exc_ovf=exc_div0=1 in one cycle -> iord_sel=3'b001, cause=01. Only one sequence runs.
- Events while busy: exc_div0 pulse -> iord_sel=3'b011; mem_data=32'hFFFF_FF7C gives pc_next=32'h0000_007C. Pulse exc_opcode during WAIT -> ignored, cause stays 11, no second sequence.
- Latency (MEM_LAT=4): any event -> busy high 6 cycles and pc_write on the 6th. Also pc_in=0 -> epc=32'hFFFF_FFFC.

Source files
------------

// File: rtl/exc_vector_ctrl_if.sv
// Signal bundle between the multicycle control unit / memory path and the
// exception sequencer that drives the memory-address mux select.
interface exc_vector_ctrl_if;
  logic [2:0]  cu_iord;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div0;
  logic [31:0] pc_in;
  logic [31:0] mem_data;
  logic [2:0]  iord_sel;
  logic [31:0] epc;
  logic        epc_write;
  logic [31:0] pc_next;
  logic        pc_write;
  logic [1:0]  cause;
  logic        busy;

  modport master (
    output cu_iord, exc_opcode, exc_ovf, exc_div0, pc_in, mem_data,
    input  iord_sel, epc, epc_write, pc_next, pc_write, cause, busy
  );

  modport slave (
    input  cu_iord, exc_opcode, exc_ovf, exc_div0, pc_in, mem_data,
    output iord_sel, epc, epc_write, pc_next, pc_write, cause, busy
  );
endinterface

// File: rtl/exc_vector_ctrl.sv
// Exception sequencer: saves the faulting PC, steers the address mux to the
// handler vector byte (253..255), waits for memory, then loads PC from it.
module exc_vector_ctrl #(
  parameter int unsigned MEM_LAT = 1,
  parameter logic [31:0] PC_ADJ  = 32'd4
) (
  input  logic            clk,
  input  logic            reset_n,
  exc_vector_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAVE,
    S_WAIT,
    S_LOAD
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_e      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_cause;
  logic [31:0] r_epc;
  logic        r_epc_write;
  logic        r_pc_write;
  logic        r_busy;

  logic [1:0]  w_new_cause;
  logic        w_unused_mem_hi;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_new_cause = 2'b00;
    if (bus.exc_opcode)    w_new_cause = 2'b01;
    else if (bus.exc_ovf)  w_new_cause = 2'b10;
    else if (bus.exc_div0) w_new_cause = 2'b11;
  end

  // NOTE: state and registered outputs use non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cause     <= 2'b00;
      r_epc       <= '0;
      r_epc_write <= 1'b0;
      r_pc_write  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_new_cause != 2'b00) begin
            r_cause     <= w_new_cause;
            r_epc_write <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_SAVE;
          end
        end
        S_SAVE: begin
          r_epc       <= bus.pc_in - PC_ADJ;
          r_epc_write <= 1'b0;
          r_cnt       <= CNT_INIT;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_pc_write <= 1'b1;
            r_state    <= S_LOAD;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_LOAD: begin
          r_pc_write <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The vector select code equals the cause code: 01->253, 10->254, 11->255.
  assign bus.iord_sel  = (r_state == S_IDLE) ? bus.cu_iord : {1'b0, r_cause};
  assign bus.pc_next   = r_pc_write ? {24'b0, bus.mem_data[7:0]} : 32'd0;
  assign bus.epc       = r_epc;
  assign bus.epc_write = r_epc_write;
  assign bus.pc_write  = r_pc_write;
  assign bus.cause     = r_cause;
  assign bus.busy      = r_busy;

  assign w_unused_mem_hi = ^bus.mem_data[31:8];

endmodule

// File: tb/tb_exc_vector_ctrl.sv
// Bench for exc_vector_ctrl: three instances (MEM_LAT 1, 3, 4) with a latency
// memory model; expected sequences are queued and checked on each pc_write.
module tb_exc_vector_ctrl;

  typedef struct {
    logic [2:0]  sel;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic [31:0] pc;
    int          lat;
  } exp_t;

  localparam int LATS [3] = '{1, 3, 4};

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  exp_t        sb_q [3][$];
  logic [31:0] mem_tbl [3][3];
  logic        busy_w [3];

  exc_vector_ctrl_if bus [3] ();

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int g, input logic [2:0] sel, input logic [1:0] cause,
                          input logic [31:0] epc, input logic [31:0] pc);
    exp_t e;
    e.sel   = sel;
    e.cause = cause;
    e.epc   = epc;
    e.pc    = pc;
    e.lat   = LATS[g];
    sb_q[g].push_back(e);
  endtask

  task automatic wait_idle(input int g);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (!busy_w[g]) done = 1'b1;
      else tick();
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle dut%0d: busy still 1, expected 0 within 30 cycles", g);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = LATS[g];

    exc_vector_ctrl #(.MEM_LAT(LAT), .PC_ADJ(32'd4)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus[g])
    );

    assign busy_w[g] = bus[g].busy;

    // Memory model: the select seen on an edge comes back LAT cycles later.
    logic [2:0] pipe [7];
    always @(posedge clk) begin
      pipe[0] <= bus[g].iord_sel;
      for (int k = 1; k < 7; k++) pipe[k] <= pipe[k-1];
    end

    always_comb begin
      bus[g].mem_data = {29'h0BAD_0000, pipe[LAT-1]};
      if (pipe[LAT-1] inside {3'd1, 3'd2, 3'd3})
        bus[g].mem_data = mem_tbl[g][pipe[LAT-1] - 3'd1];
    end

    int         busy_cnt;
    logic [2:0] epc_sel;
    bit         saw_epc;

    always @(negedge clk) begin
      if (!reset_n) begin
        busy_cnt <= 0;
        saw_epc  <= 1'b0;
      end else begin
        busy_cnt <= (bus[g].busy && !bus[g].pc_write) ? busy_cnt + 1 : 0;
        if (bus[g].epc_write) begin
          check($sformatf("dut%0d save_pc_write", g), {31'b0, bus[g].pc_write}, 32'd0);
          check($sformatf("dut%0d save_is_first_busy", g), busy_cnt, 32'd0);
          epc_sel <= bus[g].iord_sel;
          saw_epc <= 1'b1;
        end
        if (bus[g].pc_write) begin
          saw_epc <= 1'b0;
          check($sformatf("dut%0d load_epc_write", g), {31'b0, bus[g].epc_write}, 32'd0);
          if (sb_q[g].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL dut%0d unexpected_pc_write: got pc_next %h, expected no sequence",
                     g, bus[g].pc_next);
          end else begin
            exp_t e;
            e = sb_q[g].pop_front();
            check($sformatf("dut%0d saw_epc_write", g), {31'b0, saw_epc}, 32'd1);
            check($sformatf("dut%0d save_sel", g), {29'b0, epc_sel}, {29'b0, e.sel});
            check($sformatf("dut%0d load_sel", g), {29'b0, bus[g].iord_sel}, {29'b0, e.sel});
            check($sformatf("dut%0d pc_next", g), bus[g].pc_next, e.pc);
            check($sformatf("dut%0d cause", g), {30'b0, bus[g].cause}, {30'b0, e.cause});
            check($sformatf("dut%0d epc", g), bus[g].epc, e.epc);
            check($sformatf("dut%0d busy_cycles", g), busy_cnt + 1, e.lat + 2);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) mem_tbl[i][j] = 32'h5555_5555;
    mem_tbl[0][1] = 32'h1234_56A0;
    mem_tbl[0][0] = 32'h0000_0011;
    mem_tbl[1][2] = 32'hFFFF_FF7C;
    mem_tbl[2][0] = 32'hCAFE_0155;
    bus[0].cu_iord = 3'd5; bus[0].exc_opcode = 0; bus[0].exc_ovf = 0; bus[0].exc_div0 = 0; bus[0].pc_in = 0;
    bus[1].cu_iord = 3'd5; bus[1].exc_opcode = 0; bus[1].exc_ovf = 0; bus[1].exc_div0 = 0; bus[1].pc_in = 0;
    bus[2].cu_iord = 3'd5; bus[2].exc_opcode = 0; bus[2].exc_ovf = 0; bus[2].exc_div0 = 0; bus[2].pc_in = 0;

    // Reset state
    repeat (3) tick();
    check("rst iord_sel", {29'b0, bus[0].iord_sel}, 32'd5);
    check("rst busy", {31'b0, bus[0].busy}, 32'd0);
    check("rst epc", bus[0].epc, 32'd0);
    check("rst cause", {30'b0, bus[0].cause}, 32'd0);
    check("rst pc_next", bus[0].pc_next, 32'd0);
    check("rst epc_write", {31'b0, bus[0].epc_write}, 32'd0);
    check("rst pc_write", {31'b0, bus[0].pc_write}, 32'd0);
    check("rst busy dut2", {31'b0, bus[2].busy}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Passthrough sweep
    for (int i = 0; i < 8; i++) begin
      bus[0].cu_iord = 3'(i);
      tick();
      check($sformatf("pass iord_sel %0d", i), {29'b0, bus[0].iord_sel}, i);
      check("pass busy", {31'b0, bus[0].busy}, 32'd0);
      check("pass strobes", {30'b0, bus[0].epc_write, bus[0].pc_write}, 32'd0);
    end

    // Overflow, MEM_LAT=1
    bus[0].cu_iord = 3'd7;
    bus[0].pc_in   = 32'h0000_0104;
    push_exp(0, 3'b010, 2'b10, 32'h0000_0100, 32'h0000_00A0);
    bus[0].exc_ovf = 1'b1;
    tick();
    bus[0].exc_ovf = 1'b0;
    check("ovf save iord_sel", {29'b0, bus[0].iord_sel}, 32'd2);
    check("ovf save epc_write", {31'b0, bus[0].epc_write}, 32'd1);
    tick();
    check("ovf wait epc", bus[0].epc, 32'h0000_0100);
    wait_idle(0);
    tick();

    // Simultaneous events: opcode wins
    bus[0].pc_in = 32'h0000_2000;
    push_exp(0, 3'b001, 2'b01, 32'h0000_1FFC, 32'h0000_0011);
    bus[0].exc_opcode = 1'b1; bus[0].exc_ovf = 1'b1; bus[0].exc_div0 = 1'b1;
    tick();
    bus[0].exc_opcode = 1'b0; bus[0].exc_ovf = 1'b0; bus[0].exc_div0 = 1'b0;
    check("simul iord_sel", {29'b0, bus[0].iord_sel}, 32'd1);
    check("simul cause", {30'b0, bus[0].cause}, 32'd1);
    wait_idle(0);
    repeat (3) tick();

    // Div0 with events while busy, MEM_LAT=3
    bus[1].cu_iord = 3'd4;
    bus[1].pc_in   = 32'h0000_0044;
    push_exp(1, 3'b011, 2'b11, 32'h0000_0040, 32'h0000_007C);
    bus[1].exc_div0 = 1'b1;
    tick();
    bus[1].exc_div0 = 1'b0;
    check("div0 save iord_sel", {29'b0, bus[1].iord_sel}, 32'd3);
    tick();
    bus[1].exc_opcode = 1'b1;
    tick();
    bus[1].exc_opcode = 1'b0;
    check("busy opcode ignored cause", {30'b0, bus[1].cause}, 32'd3);
    check("busy opcode ignored sel", {29'b0, bus[1].iord_sel}, 32'd3);
    tick();
    tick();
    check("div0 load pc_write", {31'b0, bus[1].pc_write}, 32'd1);
    bus[1].exc_ovf = 1'b1;
    tick();
    bus[1].exc_ovf = 1'b0;
    check("load-cycle event ignored busy", {31'b0, bus[1].busy}, 32'd0);
    check("load-cycle event ignored sel", {29'b0, bus[1].iord_sel}, 32'd4);
    // First cycle back in IDLE samples normally
    bus[1].pc_in = 32'h0000_0080;
    push_exp(1, 3'b011, 2'b11, 32'h0000_007C, 32'h0000_007C);
    bus[1].exc_div0 = 1'b1;
    tick();
    bus[1].exc_div0 = 1'b0;
    check("rearm busy", {31'b0, bus[1].busy}, 32'd1);
    wait_idle(1);
    tick();

    // Latency, MEM_LAT=4, pc_in=0 wraps
    bus[2].pc_in = 32'h0000_0000;
    push_exp(2, 3'b001, 2'b01, 32'hFFFF_FFFC, 32'h0000_0055);
    bus[2].exc_opcode = 1'b1;
    tick();
    bus[2].exc_opcode = 1'b0;
    wait_idle(2);
    check("lat4 epc wrap", bus[2].epc, 32'hFFFF_FFFC);
    tick();

    // Reset in 2nd WAIT cycle, MEM_LAT=3
    bus[1].cu_iord = 3'd6;
    bus[1].pc_in   = 32'h0000_0300;
    bus[1].exc_ovf = 1'b1;
    tick();
    bus[1].exc_ovf = 1'b0;
    tick();
    tick();
    check("pre-reset epc", bus[1].epc, 32'h0000_02FC);
    reset_n = 1'b0;
    #1;
    check("midwait rst busy", {31'b0, bus[1].busy}, 32'd0);
    check("midwait rst epc", bus[1].epc, 32'd0);
    check("midwait rst cause", {30'b0, bus[1].cause}, 32'd0);
    check("midwait rst iord_sel", {29'b0, bus[1].iord_sel}, 32'd6);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("post-reset busy", {31'b0, bus[1].busy}, 32'd0);

    for (int g = 0; g < 3; g++)
      check($sformatf("dut%0d scoreboard drained", g), sb_q[g].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
